// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if: sample handshake between the upstream offset converter and the DAC serializer.
interface dac_spi_tx_if;
    logic [11:0] sample;
    logic [1:0]  pd;
    logic        sample_valid;
    logic        sample_ready;
    modport master (output sample, pd, sample_valid, input sample_ready);
    modport slave  (input sample, pd, sample_valid, output sample_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serializes {2'b00, pd, sample} into a 16-bit SPI DAC frame, MSB first, sclk idling high.
module dac_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dac_spi_tx_if.slave bus,
    output logic        o_busy,
    output logic        o_dac_sync_n,
    output logic        o_dac_sclk,
    output logic        o_dac_din,
    output logic [15:0] o_frame_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP_CYCLES - 1);
    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic [4:0]  r_half, w_half;
    logic [15:0] r_word, w_word;
    logic [15:0] r_fcnt, w_fcnt;
    logic        r_sclk, w_sclk, r_sync_n, w_sync_n, r_ready, r_busy;
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_half   = r_half;
        w_word   = r_word;
        w_fcnt   = r_fcnt;
        w_sclk   = r_sclk;
        w_sync_n = r_sync_n;
        case (r_state)
            IDLE: if (bus.sample_valid) begin
                w_state  = SHIFT;
                w_word   = {2'b00, bus.pd, bus.sample};
                w_cnt    = '0;
                w_half   = '0;
                w_sync_n = 1'b0;
                w_sclk   = 1'b1;
            end
            SHIFT: if (r_cnt == DIV_M1) begin
                w_cnt  = '0;
                w_half = r_half + 5'd1;
                w_sclk = ~r_sclk;
                // data advances only with a rising sclk so it is stable at every falling edge
                if (r_half == 5'd31) begin
                    w_state  = GAP;
                    w_sync_n = 1'b1;
                    w_word   = '0;
                    w_fcnt   = r_fcnt + 16'd1;
                end else if (!r_sclk) begin
                    w_word = r_word << 1;
                end
            end else begin
                w_cnt = r_cnt + 8'd1;
            end
            GAP: begin
                w_state = (r_cnt == GAP_M1) ? IDLE : GAP;
                w_cnt   = (r_cnt == GAP_M1) ? 8'd0 : r_cnt + 8'd1;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_half   <= '0;
            r_word   <= '0;
            r_fcnt   <= '0;
            r_sclk   <= 1'b1;
            r_sync_n <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_half   <= w_half;
            r_word   <= w_word;
            r_fcnt   <= w_fcnt;
            r_sclk   <= w_sclk;
            r_sync_n <= w_sync_n;
            r_ready  <= (w_state == IDLE);
            r_busy   <= (w_state != IDLE);
        end
    end
    assign bus.sample_ready = r_ready;
    assign o_busy           = r_busy;
    assign o_dac_sync_n     = r_sync_n;
    assign o_dac_sclk       = r_sclk;
    assign o_dac_din        = r_word[15];
    assign o_frame_cnt      = r_fcnt;
endmodule
